ram_arb: RTL and testbench

RAM_ARB -- requirements
Module: ram_arb

---
 rtl/ram_arb.sv | 120 ++++++++++++
 tb/tb_ram_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb.sv
// ram_arb: two-master arbiter for a single-port synchronous RAM.
//
// Purpose:
//   Master 0 (core LSU) and master 1 (debug/DMA) share one RAM port.
//   - A lone requester is granted in the same cycle.
//   - When both request, the master that was not granted most recently wins.
//   - Grants are combinational, so a new access can be granted every cycle.
//   - Writes complete in their grant cycle and return nothing.
//   - Read data arrives one cycle after the grant and goes back to the master
//     that issued the read.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   mX_req/we/wem/addr/wdata   request from master X (held until mX_gnt)
//   mX_gnt                request accepted this cycle (combinational)
//   mX_rvalid, mX_rdata   read response, one cycle after a read grant
//   ram_cs/we/wem/addr/din     RAM command, driven from the granted master
//   ram_dout              registered RAM read data (valid 1 cycle after read cs)
module ram_arb #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [MW-1:0] m0_wem,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [MW-1:0] m1_wem,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [MW-1:0] ram_wem,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    // last_q = 1 means master 1 received the most recent grant.
    logic last_q, last_d;
    // Outstanding read: pend_id_q names the master that owns it.
    logic pend_vld_q, pend_vld_d;
    logic pend_id_q, pend_id_d;

    // Round-robin grant. On a tie, m0 wins only if m1 was granted last.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && (!m1_req || last_q)) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    // RAM command mux. Address and data fields are zeroed when idle.
    always_comb begin
        ram_cs   = m0_gnt | m1_gnt;
        ram_we   = 1'b0;
        ram_wem  = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (m0_gnt) begin
            ram_we   = m0_we;
            ram_wem  = m0_wem;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (m1_gnt) begin
            ram_we   = m1_we;
            ram_wem  = m1_wem;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    // Next-state logic. The pointer and owner only move on a grant, while
    // pend_vld is rewritten every cycle. This lets a read grant in cycle N+1
    // overlap the response to the read granted in cycle N.
    always_comb begin
        last_d     = last_q;
        pend_id_d  = pend_id_q;
        pend_vld_d = ram_cs & ~ram_we;
        if (ram_cs) begin
            last_d    = m1_gnt;
            pend_id_d = m1_gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= 1'b1;    // m0 wins the first tie after reset
            pend_vld_q <= 1'b0;    // drops any read still in flight
            pend_id_q  <= 1'b0;
        end else begin
            last_q     <= last_d;
            pend_vld_q <= pend_vld_d;
            pend_id_q  <= pend_id_d;
        end
    end

    // Response steering. Read data is forced to zero unless valid.
    assign m0_rvalid = pend_vld_q & ~pend_id_q;
    assign m1_rvalid = pend_vld_q & pend_id_q;
    assign m0_rdata  = (m0_rvalid && !rst) ? ram_dout : '0;
    assign m1_rdata  = (m1_rvalid && !rst) ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arb.sv
// Testbench for ram_arb.
// Contains a behavioural registered-read RAM with byte-masked writes.
// Directed stimulus pushes each expected read response into a queue.
// A monitor process pops and compares entries as responses appear.
module tb_ram_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [MW-1:0] m0_wem, m1_wem;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_cs, ram_we;
    logic [MW-1:0] ram_wem;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    ram_arb #(.AW(AW), .DW(DW), .MW(MW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_wem(m0_wem), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_wem(m1_wem), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model. Preloaded while reset is high, which keeps a single writer.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (rst) begin
            mem[0]   <= 32'hA0A0_0000;   // 0x00
            mem[1]   <= 32'hA0A0_0004;   // 0x04
            mem[2]   <= 32'hA0A0_0008;   // 0x08
            mem[4]   <= 32'hDEAD_BEEF;   // 0x10
            mem[8]   <= 32'h1122_3344;   // 0x20
            mem[12]  <= 32'h9988_7766;   // 0x30
            ram_dout <= '0;
        end else if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < MW; b++)
                    if (ram_wem[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= mem[ram_addr[7:2]];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          at_cyc;
    } exp_t;
    exp_t sb[$];

    task automatic expect_rd(input logic id, input logic [31:0] data);
        exp_t e;
        e.id     = id;
        e.data   = data;
        e.at_cyc = cyc + 1;
        sb.push_back(e);
    endtask

    // Monitor: one line per returned read.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_rvalid && m1_rvalid) begin
                chk("rvalid_exclusive", 1, 0);
            end else if (m0_rvalid || m1_rvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", {63'b0, m1_rvalid}, 64'd2);
                end else begin
                    exp_t e;
                    logic [31:0] d;
                    e = sb.pop_front();
                    d = m1_rvalid ? m1_rdata : m0_rdata;
                    $display("rsp cyc=%0d m%0d data=0x%08h exp m%0d 0x%08h @%0d",
                             cyc, m1_rvalid, d, e.id, e.data, e.at_cyc);
                    chk("rsp_owner", {63'b0, m1_rvalid}, {63'b0, e.id});
                    chk("rsp_data", {32'b0, d}, {32'b0, e.data});
                    chk("rsp_cycle", 64'(cyc), 64'(e.at_cyc));
                    chk("rsp_other_rdata_zero", {32'b0, m1_rvalid ? m0_rdata : m1_rdata}, 64'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, then check both grants.
    task automatic chk_gnt(input string name, input logic g0, input logic g1);
        #1;
        $display("gnt %s cyc=%0d m0_gnt=%0b m1_gnt=%0b cs=%0b we=%0b addr=0x%0h",
                 name, cyc, m0_gnt, m1_gnt, ram_cs, ram_we, ram_addr);
        chk({name, "_m0_gnt"}, {63'b0, m0_gnt}, {63'b0, g0});
        chk({name, "_m1_gnt"}, {63'b0, m1_gnt}, {63'b0, g1});
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [3:0] wem,
                          input logic [31:0] addr, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_wem = wem; m0_addr = addr; m0_wdata = wd;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [3:0] wem,
                          input logic [31:0] addr, input logic [31:0] wd);
        m1_req = req; m1_we = we; m1_wem = wem; m1_addr = addr; m1_wdata = wd;
    endtask

    initial begin
        rst = 1'b1;
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Reset: grants, RAM strobes and responses are all held at zero.
        set_m0(1, 1, 4'hF, 32'h0, 32'h0);
        set_m1(1, 0, 4'h0, 32'h4, 32'h0);
        chk_gnt("reset", 0, 0);
        chk("reset_ram_cs", {63'b0, ram_cs}, 0);
        chk("reset_ram_we", {63'b0, ram_we}, 0);
        chk("reset_rvalid", {62'b0, m1_rvalid, m0_rvalid}, 0);
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        step();

        // Single read by m0 of 0x10.
        set_m0(1, 0, 4'h0, 32'h10, 32'h0);
        chk_gnt("single_rd", 1, 0);
        chk("single_rd_addr", {32'b0, ram_addr}, 64'h10);
        expect_rd(0, 32'hDEAD_BEEF);
        step();
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);

        // m1 byte write to 0x20 (low byte only), then m1 reads the merged word.
        set_m1(1, 1, 4'b0001, 32'h20, 32'h0000_00AA);
        chk_gnt("byte_wr", 0, 1);
        chk("byte_wr_ram_we", {63'b0, ram_we}, 1);
        step();
        set_m1(1, 0, 4'h0, 32'h20, 32'h0);
        chk_gnt("byte_rd", 0, 1);
        expect_rd(1, 32'h1122_33AA);
        step();
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        step();

        // Contention. m1 was granted last, so grants run m0, m1, m0, m1.
        set_m0(1, 0, 4'h0, 32'h0, 32'h0);
        set_m1(1, 0, 4'h0, 32'h4, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk_gnt($sformatf("rr%0d", i), (i % 2 == 0), (i % 2 == 1));
            expect_rd(i % 2 == 1, (i % 2 == 1) ? 32'hA0A0_0004 : 32'hA0A0_0000);
            step();
        end
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);

        // Back-to-back m0 reads of 0x0, 0x4 and 0x8.
        set_m0(1, 0, 4'h0, 32'h0, 32'h0);
        chk_gnt("b2b0", 1, 0);
        expect_rd(0, 32'hA0A0_0000);
        step();
        set_m0(1, 0, 4'h0, 32'h4, 32'h0);
        chk_gnt("b2b1", 1, 0);
        expect_rd(0, 32'hA0A0_0004);
        step();
        set_m0(1, 0, 4'h0, 32'h8, 32'h0);
        chk_gnt("b2b2", 1, 0);
        expect_rd(0, 32'hA0A0_0008);
        step();

        // Same cycle: m0 writes 0x30, m1 reads 0x30. m0 was granted last.
        set_m0(1, 1, 4'hF, 32'h30, 32'h0000_0055);
        set_m1(1, 0, 4'h0, 32'h30, 32'h0);
        chk_gnt("mix_rd", 0, 1);
        expect_rd(1, 32'h9988_7766);
        step();
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        chk_gnt("mix_wr", 1, 0);
        chk("mix_wr_ram_we", {63'b0, ram_we}, 1);
        step();
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(1, 0, 4'h0, 32'h30, 32'h0);
        chk_gnt("raw_rd", 0, 1);
        expect_rd(1, 32'h0000_0055);
        step();
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        step();

        // Reset mid-read: m1 read granted, then reset before its response.
        set_m1(1, 0, 4'h0, 32'h10, 32'h0);
        chk_gnt("pre_rst_rd", 0, 1);
        step();
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        chk("rst_mid_m1_rvalid", {63'b0, m1_rvalid}, 0);
        step();
        rst = 1'b0;
        step();
        step();
        // The next tie goes to m0, then to m1.
        set_m0(1, 0, 4'h0, 32'h8, 32'h0);
        set_m1(1, 0, 4'h0, 32'h4, 32'h0);
        chk_gnt("post_rst_tie", 1, 0);
        expect_rd(0, 32'hA0A0_0008);
        step();
        chk_gnt("post_rst_tie2", 0, 1);
        expect_rd(1, 32'hA0A0_0004);
        step();
        set_m0(0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 4'h0, 32'h0, 32'h0);
        chk_gnt("idle", 0, 0);

        repeat (3) step();
        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
